// File: rtl/display_timings.sv
// Raster timing generator: free-running x/y position counters that
// advance on a pixel strobe, with sync, data-enable and start flags.
// Ports: i_pix_clk clock, i_rst sync active-high reset,
//   i_pix_stb pixel strobe, o_x/o_y 16-bit position,
//   o_hs/o_vs syncs at H_POL/V_POL, o_de active area,
//   o_line start of line, o_frame start of frame.
module display_timings #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_line,
  output logic        o_frame
);

  localparam logic [15:0] H_TOTAL =
    16'(H_RES + H_FP + H_SYNC + H_BP);
  localparam logic [15:0] V_TOTAL =
    16'(V_RES + V_FP + V_SYNC + V_BP);

  localparam logic [15:0] H_ACT = 16'(H_RES);
  localparam logic [15:0] V_ACT = 16'(V_RES);
  localparam logic [15:0] HS_BEG = 16'(H_RES + H_FP);
  localparam logic [15:0] HS_END =
    16'(H_RES + H_FP + H_SYNC);
  localparam logic [15:0] VS_BEG = 16'(V_RES + V_FP);
  localparam logic [15:0] VS_END =
    16'(V_RES + V_FP + V_SYNC);

  localparam logic [15:0] H_LAST = H_TOTAL - 16'd1;
  localparam logic [15:0] V_LAST = V_TOTAL - 16'd1;

  logic x_wrap;
  logic y_wrap;

  assign x_wrap = (o_x == H_LAST);
  assign y_wrap = (o_y == V_LAST);

  // y only moves on the strobe where x wraps, so the
  // last pixel of the frame rolls straight to (0,0).
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_x <= '0;
      o_y <= '0;
    end else if (i_pix_stb) begin
      if (x_wrap) begin
        o_x <= '0;
        o_y <= y_wrap ? '0 : o_y + 16'd1;
      end else begin
        o_x <= o_x + 16'd1;
      end
    end
  end

  logic h_act;
  logic v_act;
  logic h_syn;
  logic v_syn;

  always_comb begin
    h_act   = 1'b0;
    v_act   = 1'b0;
    h_syn   = 1'b0;
    v_syn   = 1'b0;
    o_de    = 1'b0;
    o_hs    = ~H_POL;
    o_vs    = ~V_POL;
    o_line  = 1'b0;
    o_frame = 1'b0;

    h_act = (o_x < H_ACT);
    v_act = (o_y < V_ACT);
    h_syn = (o_x >= HS_BEG) && (o_x < HS_END);
    v_syn = (o_y >= VS_BEG) && (o_y < VS_END);

    o_de    = h_act && v_act;
    o_hs    = h_syn ? H_POL : ~H_POL;
    o_vs    = v_syn ? V_POL : ~V_POL;
    o_line  = (o_x == 16'd0);
    o_frame = (o_x == 16'd0) && (o_y == 16'd0);
  end

endmodule

// File: tb/tb_display_timings.sv
// Bench for display_timings: three builds (default VGA, small raster,
// VGA line with active-high syncs) against a pixel-index model.
module tb_display_timings;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b1;
  bit   run = 1'b0;

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // --- build A: defaults
  logic [15:0] a_x, a_y;
  logic a_hs, a_vs, a_de, a_line, a_frame;

  display_timings u_a (
    .i_pix_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_x(a_x), .o_y(a_y), .o_hs(a_hs), .o_vs(a_vs),
    .o_de(a_de), .o_line(a_line), .o_frame(a_frame)
  );

  // --- build B: tiny raster, 14 x 11
  logic [15:0] b_x, b_y;
  logic b_hs, b_vs, b_de, b_line, b_frame;

  display_timings #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_RES(6), .V_FP(2), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .i_pix_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_x(b_x), .o_y(b_y), .o_hs(b_hs), .o_vs(b_vs),
    .o_de(b_de), .o_line(b_line), .o_frame(b_frame)
  );

  // --- build C: VGA line, 5 lines, active-high syncs
  logic [15:0] c_x, c_y;
  logic c_hs, c_vs, c_de, c_line, c_frame;

  display_timings #(
    .V_RES(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_c (
    .i_pix_clk(clk), .i_rst(rst), .i_pix_stb(stb),
    .o_x(c_x), .o_y(c_y), .o_hs(c_hs), .o_vs(c_vs),
    .o_de(c_de), .o_line(c_line), .o_frame(c_frame)
  );

  // Model: each build is a linear pixel index modulo the frame size.
  localparam int FT_A = 800 * 525;
  localparam int FT_B = 14 * 11;
  localparam int FT_C = 800 * 5;

  int n_a = 0;
  int n_b = 0;
  int n_c = 0;

  always @(posedge clk) begin
    if (rst) begin
      n_a <= 0;
      n_b <= 0;
      n_c <= 0;
    end else if (stb) begin
      n_a <= (n_a + 1) % FT_A;
      n_b <= (n_b + 1) % FT_B;
      n_c <= (n_c + 1) % FT_C;
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d, expected %0d",
                 nm, act, exp);
    end
  endtask

  task automatic check_dut(
    input string tag, input int n,
    input int hr, input int hf, input int hsw, input int hb,
    input int vr, input int vf, input int vsw,
    input bit hp, input bit vp,
    input int x, input int y,
    input bit hs, input bit vs, input bit de,
    input bit ln, input bit fr);
    int ht, ex, ey;
    bit e_hs, e_vs;
    ht = hr + hf + hsw + hb;
    ex = n % ht;
    ey = n / ht;
    e_hs = (ex >= hr + hf && ex < hr + hf + hsw) ? hp : !hp;
    e_vs = (ey >= vr + vf && ey < vr + vf + vsw) ? vp : !vp;
    chk({tag, ".x"}, x, ex);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".de"}, int'(de), int'(ex < hr && ey < vr));
    chk({tag, ".hs"}, int'(hs), int'(e_hs));
    chk({tag, ".vs"}, int'(vs), int'(e_vs));
    chk({tag, ".line"}, int'(ln), int'(ex == 0));
    chk({tag, ".frame"}, int'(fr), int'(ex == 0 && ey == 0));
  endtask

  always @(negedge clk) begin
    if (run) begin
      check_dut("A", n_a, 640, 16, 96, 48, 480, 10, 2,
                1'b0, 1'b0, int'(a_x), int'(a_y),
                a_hs, a_vs, a_de, a_line, a_frame);
      check_dut("B", n_b, 8, 2, 3, 1, 6, 2, 2,
                1'b0, 1'b0, int'(b_x), int'(b_y),
                b_hs, b_vs, b_de, b_line, b_frame);
      check_dut("C", n_c, 640, 16, 96, 48, 2, 1, 1,
                1'b1, 1'b1, int'(c_x), int'(c_y),
                c_hs, c_vs, c_de, c_line, c_frame);
    end
  end

  task automatic tick(input logic s, input logic r);
    stb = s;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int k);
    for (int i = 0; i < k; i++) tick(1'b1, 1'b0);
  endtask

  int  rises;
  bit  prev_fr;

  initial begin
    // reset with strobe high throughout
    tick(1'b1, 1'b1);
    run = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("rst.a_x", int'(a_x), 0);
    chk("rst.a_y", int'(a_y), 0);
    chk("rst.a_de", int'(a_de), 1);
    chk("rst.a_line", int'(a_line), 1);
    chk("rst.a_frame", int'(a_frame), 1);
    chk("rst.a_hs", int'(a_hs), 1);
    chk("rst.a_vs", int'(a_vs), 1);
    chk("rst.c_hs", int'(c_hs), 0);
    chk("rst.c_vs", int'(c_vs), 0);

    // end of first line
    strobes(799);
    chk("l0.x", int'(a_x), 799);
    chk("l0.y", int'(a_y), 0);
    chk("l0.line", int'(a_line), 0);
    strobes(1);
    chk("l1.x", int'(a_x), 0);
    chk("l1.y", int'(a_y), 1);
    chk("l1.line", int'(a_line), 1);

    // three full frames of B, one frame interval each
    tick(1'b1, 1'b1);
    rises = 0;
    prev_fr = b_frame;
    for (int i = 0; i < 3 * FT_B; i++) begin
      tick(1'b1, 1'b0);
      if (b_frame && !prev_fr) rises++;
      prev_fr = b_frame;
    end
    chk("b_frames", rises, 3);
    chk("b_wrap.x", int'(b_x), 0);
    chk("b_wrap.y", int'(b_y), 0);
    chk("b_wrap.frame", int'(b_frame), 1);

    // freeze B at last active pixel (7,5)
    tick(1'b1, 1'b1);
    strobes(77);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      chk("b_hold.x", int'(b_x), 7);
      chk("b_hold.y", int'(b_y), 5);
      chk("b_hold.de", int'(b_de), 1);
    end
    strobes(1);
    chk("b_step.x", int'(b_x), 8);
    chk("b_step.de", int'(b_de), 0);

    // freeze A at (639,0)
    tick(1'b1, 1'b1);
    strobes(639);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      chk("a_hold.x", int'(a_x), 639);
      chk("a_hold.de", int'(a_de), 1);
    end
    strobes(1);
    chk("a_step.x", int'(a_x), 640);
    chk("a_step.de", int'(a_de), 0);

    // reset pulse mid-frame at C (700,3)
    tick(1'b1, 1'b1);
    strobes(3 * 800 + 700);
    chk("mid.c_x", int'(c_x), 700);
    chk("mid.c_y", int'(c_y), 3);
    tick(1'b1, 1'b1);
    chk("mid_rst.c_x", int'(c_x), 0);
    chk("mid_rst.c_y", int'(c_y), 0);
    chk("mid_rst.c_frame", int'(c_frame), 1);
    chk("mid_rst.a_frame", int'(a_frame), 1);
    strobes(1);
    chk("post_rst.a_x", int'(a_x), 1);
    chk("post_rst.a_y", int'(a_y), 0);

    // active-high hsync edges on C
    tick(1'b1, 1'b1);
    strobes(655);
    chk("c_hs655", int'(c_hs), 0);
    strobes(1);
    chk("c_hs656", int'(c_hs), 1);
    strobes(95);
    chk("c_hs751", int'(c_hs), 1);
    strobes(1);
    chk("c_hs752", int'(c_hs), 0);

    // irregular strobe pattern
    tick(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++)
      tick(1'($urandom_range(0, 1)), 1'b0);

    @(negedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
